// File: rtl/arm_instr_encoder_pkg.sv
// Shared encoding constants and types for the ARM instruction encoder.
// The ID control unit imports the same mode and opcode definitions.
package arm_instr_encoder_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH   = 2'b00,
    MODE_MEM     = 2'b01,
    MODE_BRANCH  = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] MEM_PUBW = 4'b1100;
  localparam logic [3:0] COND_AL  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_FULL
  } state_e;

  function automatic logic arith_op_legal(input logic [3:0] op);
    case (op)
      OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_instr_encoder_if.sv
// Request and word-stream handshake bundle of the ARM instruction encoder.
// The slave modport is the encoder's view; master is the loader/consumer side.
interface arm_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [1:0]  in_mode;
  logic [3:0]  in_opcode;
  logic        in_s;
  logic        in_imm;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [23:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport slave (
    input  in_valid, in_cond, in_mode, in_opcode, in_s, in_imm,
           in_rn, in_rd, in_operand, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_cond, in_mode, in_opcode, in_s, in_imm,
           in_rn, in_rd, in_operand, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/arm_instr_encoder_pack.sv
// Combinational ARM field packer: builds the 32-bit word for one request
// and flags whether the request is a legal, emittable instruction.
module arm_instr_pack
  import arm_instr_encoder_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [1:0]  mode,
  input  logic [3:0]  opcode,
  input  logic        s,
  input  logic        imm,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [23:0] operand,
  output logic [31:0] instr,
  output logic        legal
);
  logic       s_f;
  logic [3:0] rn_f;
  logic [3:0] rd_f;

  always_comb begin
    instr = '0;
    legal = 1'b0;
    s_f   = s;
    rn_f  = rn;
    rd_f  = rd;
    case (mode_e'(mode))
      MODE_ARITH: begin
        legal = arith_op_legal(opcode);
        // MOV/MVN take no first operand; CMP/TST always set flags and write no Rd
        if (opcode == OP_MOV || opcode == OP_MVN) rn_f = '0;
        if (opcode == OP_CMP || opcode == OP_TST) begin
          s_f  = 1'b1;
          rd_f = '0;
        end
        instr = {cond, MODE_ARITH, imm, opcode, s_f, rn_f, rd_f, operand[11:0]};
      end
      MODE_MEM: begin
        legal = 1'b1;
        instr = {cond, MODE_MEM, 1'b0, MEM_PUBW, s, rn, rd, operand[11:0]};
      end
      MODE_BRANCH: begin
        legal = 1'b1;
        instr = {cond, MODE_BRANCH, 2'b10, operand};
      end
      default: begin
        legal = 1'b0;
        instr = '0;
      end
    endcase
  end
endmodule

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: accepts decoded-style requests and streams packed
// words with sequential byte addresses through a one-stage output register.
module arm_instr_encoder
  import arm_instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  arm_instr_encoder_if.slave  bus,
  output logic [6:0]          word_count,
  output logic                err
);
  localparam logic [6:0] LAST = 7'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        in_ready_c;
  logic [31:0] packed_instr;
  logic        packed_legal;

  arm_instr_pack u_pack (
    .cond    (bus.in_cond),
    .mode    (bus.in_mode),
    .opcode  (bus.in_opcode),
    .s       (bus.in_s),
    .imm     (bus.in_imm),
    .rn      (bus.in_rn),
    .rd      (bus.in_rd),
    .operand (bus.in_operand),
    .instr   (packed_instr),
    .legal   (packed_legal)
  );

  always_comb begin
    state_d     = state_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    count_d     = count_q;
    err_d       = err_q;
    in_ready_c  = 1'b0;

    // The pop that reaches DEPTH closes the intake in the same cycle so no
    // request is accepted and then dropped on the way into FULL.
    case (state_q)
      ST_IDLE: in_ready_c = !clear;
      ST_HOLD: in_ready_c = !clear && bus.out_ready && (count_q != LAST);
      default: in_ready_c = 1'b0;
    endcase

    if (state_q == ST_HOLD && bus.out_ready) begin
      count_d    = count_q + 7'd1;
      out_addr_d = out_addr_q + 32'd4;
      state_d    = (count_q == LAST) ? ST_FULL : ST_IDLE;
    end

    if (bus.in_valid && in_ready_c) begin
      if (packed_legal) begin
        out_instr_d = packed_instr;
        state_d     = ST_HOLD;
      end else begin
        err_d = 1'b1;
      end
    end

    if (clear) begin
      state_d     = ST_IDLE;
      out_instr_d = '0;
      out_addr_d  = BASE_ADDR;
      count_d     = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign word_count    = count_q;
  assign err           = err_q;
endmodule

// File: tb/tb_arm_instr_encoder.sv
// Bench for arm_instr_encoder: fixed encoding vectors, handshake corner
// sequences, and a randomized run checked against a word-queue reference.
module tb_arm_instr_encoder;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [6:0] word_count;
  logic       err;

  arm_instr_encoder_if bus ();

  arm_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  mode;
    logic [3:0]  op;
    logic        s;
    logic        imm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] operand;
    logic [31:0] exp_word;
    logic        exp_legal;
  } vec_t;

  vec_t vecs [11];

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  int unsigned m_count = 0;
  bit          m_err   = 1'b0;
  logic [31:0] pop_addr [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Field weights written as plain arithmetic from the instruction layout.
  function automatic logic [31:0] ref_encode(
    input logic [3:0] cond, input logic [1:0] mode, input logic [3:0] op,
    input logic s, input logic imm, input logic [3:0] rn, input logic [3:0] rd,
    input logic [23:0] operand, output bit legal);
    int unsigned w, o, r_n, r_d, sb, off12;
    o     = op;
    r_n   = rn;
    r_d   = rd;
    sb    = s;
    off12 = operand % 4096;
    w     = cond * 268435456 + mode * 67108864;
    legal = 1'b1;
    case (mode)
      2'd0: begin
        legal = (o inside {13, 15, 4, 5, 2, 6, 0, 12, 1, 10, 8});
        if (o == 13 || o == 15) r_n = 0;
        if (o == 10 || o == 8) begin
          sb  = 1;
          r_d = 0;
        end
        w = w + imm * 33554432 + o * 2097152 + sb * 1048576 + r_n * 65536 + r_d * 4096 + off12;
      end
      2'd1: w = w + 12 * 2097152 + sb * 1048576 + r_n * 65536 + r_d * 4096 + off12;
      2'd2: w = w + 33554432 + operand;
      default: legal = 1'b0;
    endcase
    return w;
  endfunction

  task automatic set_req(input vec_t v);
    bus.in_cond    = v.cond;
    bus.in_mode    = v.mode;
    bus.in_opcode  = v.op;
    bus.in_s       = v.s;
    bus.in_imm     = v.imm;
    bus.in_rn      = v.rn;
    bus.in_rd      = v.rd;
    bus.in_operand = v.operand;
  endtask

  // Called just after a falling edge with inputs settled: compare outputs
  // to the reference, advance the reference across the next rising edge.
  task automatic cycle();
    bit          exp_rdy;
    bit          legal;
    logic [31:0] w;
    #1;
    exp_rdy = !clear && (m_count < DEPTH) &&
              (exp_q.size() == 0 || (bus.out_ready && (m_count + 1 < DEPTH)));
    if (rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_instr", bus.out_instr, exp_q[0]);
      chk("out_addr", bus.out_addr, BASE + 4 * m_count);
      chk("word_count", 32'(word_count), m_count);
      chk("err", 32'(err), 32'(m_err));
    end
    if (!rst_n || clear) begin
      exp_q.delete();
      m_count = 0;
      m_err   = 1'b0;
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) begin
        pop_addr.push_back(bus.out_addr);
        void'(exp_q.pop_front());
        m_count++;
      end
      if (bus.in_valid && exp_rdy) begin
        w = ref_encode(bus.in_cond, bus.in_mode, bus.in_opcode, bus.in_s, bus.in_imm,
                       bus.in_rn, bus.in_rd, bus.in_operand, legal);
        if (legal) exp_q.push_back(w);
        else m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{4'hE, 2'd0, 4'h4, 1'b0, 1'b1, 4'd2, 4'd1, 24'h000005, 32'hE2821005, 1'b1};
    vecs[1]  = '{4'hE, 2'd0, 4'hA, 1'b0, 1'b0, 4'd3, 4'd7, 24'h000004, 32'hE1530004, 1'b1};
    vecs[2]  = '{4'hE, 2'd1, 4'h7, 1'b1, 1'b1, 4'd1, 4'd0, 24'h000008, 32'hE5910008, 1'b1};
    vecs[3]  = '{4'hE, 2'd2, 4'h3, 1'b1, 1'b0, 4'd5, 4'd6, 24'hFFFFFE, 32'hEAFFFFFE, 1'b1};
    vecs[4]  = '{4'hE, 2'd0, 4'hD, 1'b0, 1'b1, 4'd5, 4'd0, 24'hABC0FF, 32'hE3A000FF, 1'b1};
    vecs[5]  = '{4'hE, 2'd0, 4'hF, 1'b1, 1'b0, 4'd9, 4'd2, 24'h000003, 32'hE1F02003, 1'b1};
    vecs[6]  = '{4'hE, 2'd0, 4'h8, 1'b0, 1'b1, 4'd5, 4'd6, 24'h000001, 32'hE3150001, 1'b1};
    vecs[7]  = '{4'h0, 2'd1, 4'h2, 1'b0, 1'b0, 4'd4, 4'd3, 24'h000010, 32'h05843010, 1'b1};
    vecs[8]  = '{4'h1, 2'd0, 4'h2, 1'b1, 1'b1, 4'd8, 4'd7, 24'h000003, 32'h12587003, 1'b1};
    vecs[9]  = '{4'hE, 2'd0, 4'h3, 1'b0, 1'b0, 4'd1, 4'd2, 24'h000003, 32'h00000000, 1'b0};
    vecs[10] = '{4'hE, 2'd3, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 24'h000003, 32'h00000000, 1'b0};

    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(vecs[0]);
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_addr", bus.out_addr, 32'h0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();

    // Encoding table: each vector from a cleared state, word held unconsumed.
    foreach (vecs[i]) begin
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      set_req(vecs[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      cycle();
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_legal));
      if (vecs[i].exp_legal) chk($sformatf("vec%0d_word", i), bus.out_instr, vecs[i].exp_word);
      else chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
      cycle();
    end

    // Backpressure then back-to-back drain.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    set_req(vecs[0]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    cycle();
    set_req(vecs[1]);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_instr", bus.out_instr, 32'hE2821005);
      cycle();
    end
    bus.out_ready = 1'b1;
    pop_addr.delete();
    cycle();
    set_req(vecs[2]);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    chk("b2b_pops", 32'(pop_addr.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < pop_addr.size()) chk($sformatf("b2b_addr%0d", k), pop_addr[k], 32'(4 * k));
    #1;
    chk("b2b_count", 32'(word_count), 32'd3);
    cycle();

    // Illegal request, then fill to DEPTH, then clear.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    set_req(vecs[10]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(word_count), 32'd0);
    chk("ill_addr", bus.out_addr, 32'h0);
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_req(vecs[k % 9]);
      cycle();
    end
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_valid", 32'(bus.out_valid), 32'd0);
    chk("full_count", 32'(word_count), 32'd4);
    chk("full_addr", bus.out_addr, 32'd16);
    chk("full_err", 32'(err), 32'd1);
    clear = 1'b1;
    cycle();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_addr", bus.out_addr, 32'h0);
    chk("clr_count", 32'(word_count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    cycle();

    // Randomized traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      clear          = ($urandom_range(0, 39) == 0);
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.out_ready  = ($urandom_range(0, 9) < 6);
      bus.in_cond    = 4'($urandom);
      bus.in_mode    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.in_opcode  = 4'($urandom);
      bus.in_s       = 1'($urandom);
      bus.in_imm     = 1'($urandom);
      bus.in_rn      = 4'($urandom);
      bus.in_rd      = 4'($urandom);
      bus.in_operand = 24'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
